// File: rtl/axi_reg_channel.sv
`default_nettype none
// ============================================================================
//  Module   : axi_reg_channel
//  Purpose  : Valid/ready register slice. Combinational bypass (MODE=0), a
//             cascade of forward registers (MODE=1) or a cascade of
//             main+skid buffers with fully registered ready (MODE=2).
//             Tracks the number of beats held in the channel.
//  Revision : 1.0 - initial release
// ============================================================================
module axi_reg_channel #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_STAGES = 2,
  parameter int MODE       = 2
) (
  input  logic                                  clk,
  input  logic                                  arst,
  input  logic                                  in_valid,
  input  logic [DATA_WIDTH-1:0]                 in_data,
  output logic                                  in_ready,
  output logic                                  out_valid,
  output logic [DATA_WIDTH-1:0]                 out_data,
  input  logic                                  out_ready,
  output logic [$clog2(2*NUM_STAGES+1)-1:0]     occupancy,
  output logic                                  idle
);

  localparam int                 c_OCC_W   = $clog2(2*NUM_STAGES+1);
  localparam logic [c_OCC_W-1:0] c_OCC_ONE = 1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

  assign idle = (occupancy == '0);

  generate
    if (MODE == 0) begin : g_bypass
      // Pure wires: clock and reset have no work to do here
      logic w_unused;
      assign w_unused  = clk ^ arst;
      assign out_valid = in_valid;
      assign out_data  = in_data;
      assign in_ready  = out_ready;
      assign occupancy = '0;
    end else begin : g_staged
      logic               w_in_hs;
      logic               w_out_hs;
      logic [c_OCC_W-1:0] r_occ;

      assign w_in_hs   = in_valid & in_ready;
      assign w_out_hs  = out_valid & out_ready;
      assign occupancy = r_occ;

      // Beat counter: +1 on accept, -1 on emit, unchanged when both happen
      always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
          r_occ <= '0;
        end else begin
          case ({w_in_hs, w_out_hs})
            2'b10:   r_occ <= r_occ + c_OCC_ONE;
            2'b01:   r_occ <= r_occ - c_OCC_ONE;
            default: r_occ <= r_occ;
          endcase
        end
      end

      if (MODE == 1) begin : g_fwd
        logic                  r_live;
        logic [NUM_STAGES-1:0] r_valid;
        logic [DATA_WIDTH-1:0] r_data [NUM_STAGES];
        logic [NUM_STAGES:0]   w_rdy;
        logic [NUM_STAGES-1:0] w_upv;
        logic [DATA_WIDTH-1:0] w_upd [NUM_STAGES];

        // Ready ripples back from the sink; upstream view of each stage input
        always_comb begin
          w_rdy             = '0;
          w_rdy[NUM_STAGES] = out_ready;
          for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            w_rdy[k] = r_live & (w_rdy[k+1] | ~r_valid[k]);
          end
          w_upv    = '0;
          w_upv[0] = in_valid;
          w_upd[0] = in_data;
          for (int k = 1; k < NUM_STAGES; k++) begin
            w_upv[k] = r_valid[k-1];
            w_upd[k] = r_data[k-1];
          end
        end

        // Stage registers load whenever the stage is ready; r_live holds ready low in reset
        always_ff @(posedge clk or posedge arst) begin
          if (arst) begin
            r_live  <= 1'b0;
            r_valid <= '0;
            for (int k = 0; k < NUM_STAGES; k++) begin
              r_data[k] <= '0;
            end
          end else begin
            r_live <= 1'b1;
            for (int k = 0; k < NUM_STAGES; k++) begin
              if (w_rdy[k]) begin
                r_valid[k] <= w_upv[k];
                if (w_upv[k]) begin
                  r_data[k] <= w_upd[k];
                end
              end
            end
          end
        end

        assign in_ready  = w_rdy[0];
        assign out_valid = r_valid[NUM_STAGES-1];
        assign out_data  = r_data[NUM_STAGES-1];
      end else begin : g_skid
        skid_state_t           r_state [NUM_STAGES];
        logic [NUM_STAGES-1:0] r_rdy;
        logic [DATA_WIDTH-1:0] r_main  [NUM_STAGES];
        logic [DATA_WIDTH-1:0] r_skid  [NUM_STAGES];
        logic [NUM_STAGES-1:0] w_upv;
        logic [NUM_STAGES-1:0] w_dnr;
        logic [NUM_STAGES-1:0] w_push;
        logic [NUM_STAGES-1:0] w_pop;
        logic [DATA_WIDTH-1:0] w_upd   [NUM_STAGES];

        // Handshakes per stage; every ready comes straight from a register
        always_comb begin
          w_upv    = '0;
          w_dnr    = '0;
          w_push   = '0;
          w_pop    = '0;
          w_upv[0] = in_valid;
          w_upd[0] = in_data;
          for (int k = 1; k < NUM_STAGES; k++) begin
            w_upv[k] = (r_state[k-1] != ST_EMPTY);
            w_upd[k] = r_main[k-1];
          end
          for (int k = 0; k < NUM_STAGES - 1; k++) begin
            w_dnr[k] = r_rdy[k+1];
          end
          w_dnr[NUM_STAGES-1] = out_ready;
          for (int k = 0; k < NUM_STAGES; k++) begin
            w_push[k] = w_upv[k] & r_rdy[k];
            w_pop[k]  = (r_state[k] != ST_EMPTY) & w_dnr[k];
          end
        end

        // Per-stage EMPTY/BUSY/FULL machine; ready is registered as (next state != FULL)
        always_ff @(posedge clk or posedge arst) begin
          if (arst) begin
            r_rdy <= '0;
            for (int k = 0; k < NUM_STAGES; k++) begin
              r_state[k] <= ST_EMPTY;
              r_main[k]  <= '0;
              r_skid[k]  <= '0;
            end
          end else begin
            for (int k = 0; k < NUM_STAGES; k++) begin
              case (r_state[k])
                ST_EMPTY: begin
                  r_rdy[k] <= 1'b1;
                  if (w_push[k]) begin
                    r_main[k]  <= w_upd[k];
                    r_state[k] <= ST_BUSY;
                  end
                end
                ST_BUSY: begin
                  r_rdy[k] <= 1'b1;
                  if (w_push[k] && !w_pop[k]) begin
                    r_skid[k]  <= w_upd[k];
                    r_state[k] <= ST_FULL;
                    r_rdy[k]   <= 1'b0;
                  end else if (w_pop[k] && !w_push[k]) begin
                    r_state[k] <= ST_EMPTY;
                  end else if (w_push[k] && w_pop[k]) begin
                    r_main[k] <= w_upd[k];
                  end
                end
                ST_FULL: begin
                  // Ready is low here, so only a pop can happen
                  if (w_pop[k]) begin
                    r_main[k]  <= r_skid[k];
                    r_state[k] <= ST_BUSY;
                    r_rdy[k]   <= 1'b1;
                  end else begin
                    r_rdy[k] <= 1'b0;
                  end
                end
                default: begin
                  r_state[k] <= ST_EMPTY;
                  r_rdy[k]   <= 1'b1;
                end
              endcase
            end
          end
        end

        assign in_ready  = r_rdy[0];
        assign out_valid = (r_state[NUM_STAGES-1] != ST_EMPTY);
        assign out_data  = r_main[NUM_STAGES-1];
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_axi_reg_channel.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_reg_channel
//  Purpose  : Self-checking bench for axi_reg_channel in all three modes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_reg_channel;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic arst;

  // MODE=2, NUM_STAGES=2
  logic        a_iv, a_ir, a_ov, a_or, a_idle;
  logic [31:0] a_id, a_od;
  logic [2:0]  a_occ;
  // MODE=1, NUM_STAGES=3
  logic        b_iv, b_ir, b_ov, b_or, b_idle;
  logic [31:0] b_id, b_od;
  logic [2:0]  b_occ;
  // MODE=0
  logic        z_iv, z_ir, z_ov, z_or, z_idle;
  logic [31:0] z_id, z_od;
  logic [2:0]  z_occ;

  axi_reg_channel #(.DATA_WIDTH(32), .NUM_STAGES(2), .MODE(2)) u_a (
    .clk(clk), .arst(arst), .in_valid(a_iv), .in_data(a_id), .in_ready(a_ir),
    .out_valid(a_ov), .out_data(a_od), .out_ready(a_or), .occupancy(a_occ), .idle(a_idle));
  axi_reg_channel #(.DATA_WIDTH(32), .NUM_STAGES(3), .MODE(1)) u_b (
    .clk(clk), .arst(arst), .in_valid(b_iv), .in_data(b_id), .in_ready(b_ir),
    .out_valid(b_ov), .out_data(b_od), .out_ready(b_or), .occupancy(b_occ), .idle(b_idle));
  axi_reg_channel #(.DATA_WIDTH(32), .NUM_STAGES(2), .MODE(0)) u_z (
    .clk(clk), .arst(arst), .in_valid(z_iv), .in_data(z_id), .in_ready(z_ir),
    .out_valid(z_ov), .out_data(z_od), .out_ready(z_or), .occupancy(z_occ), .idle(z_idle));

  int n_err = 0;
  int n_chk = 0;

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
    logic [2:0]  e_occ;
  } vec2_t;

  typedef struct {
    logic        ordy;
    logic        iv;
    logic [31:0] id;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
  } vec0_t;

  vec2_t v2 [10];
  vec0_t v0 [4];

  logic [31:0] qa [$];
  logic [31:0] qb [$];

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int          ma, mb, a_seq, b_seq;
    logic        tmp_ir, a_stall;
    logic [31:0] a_prev_od, exp_d;

    // Skid fill with sink stalled, then drain back-to-back
    v2[0] = '{1'b1, 32'h1, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0};
    v2[1] = '{1'b1, 32'h2, 1'b0, 1'b1, 1'b0, 32'h0, 3'd1};
    v2[2] = '{1'b1, 32'h3, 1'b0, 1'b1, 1'b1, 32'h1, 3'd2};
    v2[3] = '{1'b1, 32'h4, 1'b0, 1'b1, 1'b1, 32'h1, 3'd3};
    v2[4] = '{1'b1, 32'h5, 1'b0, 1'b0, 1'b1, 32'h1, 3'd4};
    v2[5] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h1, 3'd4};
    v2[6] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h2, 3'd3};
    v2[7] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h3, 3'd2};
    v2[8] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h4, 3'd1};
    v2[9] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 3'd0};

    v0[0] = '{1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 32'hDEADBEEF};
    v0[1] = '{1'b1, 1'b0, 32'h12345678, 1'b1, 1'b0, 32'h12345678};
    v0[2] = '{1'b1, 1'b1, 32'h00000000, 1'b1, 1'b1, 32'h00000000};
    v0[3] = '{1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFF};

    arst = 1'b1;
    a_iv = 1'b0; a_id = '0; a_or = 1'b0;
    b_iv = 1'b0; b_id = '0; b_or = 1'b0;
    z_iv = 1'b0; z_id = '0; z_or = 1'b0;

    // Reset state
    #12;
    chk_b("a_rst_ov", a_ov, 1'b0);
    chk_w("a_rst_od", a_od, 32'h0);
    chk_w("a_rst_occ", 32'(a_occ), 32'd0);
    chk_b("a_rst_idle", a_idle, 1'b1);
    chk_b("a_rst_ir", a_ir, 1'b0);
    chk_b("b_rst_ov", b_ov, 1'b0);
    chk_b("b_rst_ir", b_ir, 1'b0);
    #10;
    arst = 1'b0;
    #1;
    chk_b("a_ir_before_edge", a_ir, 1'b0);
    chk_b("b_ir_before_edge", b_ir, 1'b0);
    next_cycle();
    chk_b("a_ir_after_edge", a_ir, 1'b1);
    chk_b("b_ir_after_edge", b_ir, 1'b1);

    // Bypass mode table
    for (int i = 0; i < 4; i++) begin
      z_or = v0[i].ordy; z_iv = v0[i].iv; z_id = v0[i].id;
      #1;
      chk_b("z_ir", z_ir, v0[i].e_ir);
      chk_b("z_ov", z_ov, v0[i].e_ov);
      chk_w("z_od", z_od, v0[i].e_od);
      chk_w("z_occ", 32'(z_occ), 32'd0);
      chk_b("z_idle", z_idle, 1'b1);
    end

    // Skid fill/drain table
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      a_iv = v2[i].iv; a_id = v2[i].id; a_or = v2[i].ordy;
      @(negedge clk);
      chk_b("a_tab_ir", a_ir, v2[i].e_ir);
      chk_b("a_tab_ov", a_ov, v2[i].e_ov);
      if (v2[i].e_ov) chk_w("a_tab_od", a_od, v2[i].e_od);
      chk_w("a_tab_occ", 32'(a_occ), 32'(v2[i].e_occ));
    end

    // Single beat latency through two skid stages
    next_cycle();
    a_iv = 1'b1; a_id = 32'hA5A5A5A5; a_or = 1'b1;
    @(negedge clk);
    chk_b("a_lat_ir", a_ir, 1'b1);
    chk_w("a_lat_occ0", 32'(a_occ), 32'd0);
    next_cycle();
    a_iv = 1'b0;
    @(negedge clk);
    chk_b("a_lat_ov1", a_ov, 1'b0);
    chk_w("a_lat_occ1", 32'(a_occ), 32'd1);
    next_cycle();
    @(negedge clk);
    chk_b("a_lat_ov2", a_ov, 1'b1);
    chk_w("a_lat_od2", a_od, 32'hA5A5A5A5);
    chk_w("a_lat_occ2", 32'(a_occ), 32'd1);
    next_cycle();
    @(negedge clk);
    chk_b("a_lat_ov3", a_ov, 1'b0);
    chk_w("a_lat_occ3", 32'(a_occ), 32'd0);
    chk_b("a_lat_idle3", a_idle, 1'b1);

    // Asynchronous reset with three beats held
    next_cycle();
    a_iv = 1'b1; a_id = 32'h11; a_or = 1'b0;
    next_cycle();
    a_id = 32'h22;
    next_cycle();
    a_id = 32'h33;
    next_cycle();
    a_iv = 1'b0;
    @(negedge clk);
    chk_w("a_pre_rst_occ", 32'(a_occ), 32'd3);
    #1;
    arst = 1'b1;
    #1;
    chk_b("a_arst_ov", a_ov, 1'b0);
    chk_w("a_arst_occ", 32'(a_occ), 32'd0);
    chk_b("a_arst_idle", a_idle, 1'b1);
    chk_b("a_arst_ir", a_ir, 1'b0);
    chk_w("a_arst_od", a_od, 32'h0);
    @(posedge clk);
    #2;
    arst = 1'b0;
    a_or = 1'b1;
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      @(negedge clk);
      chk_b("a_post_rst_ov", a_ov, 1'b0);
      chk_w("a_post_rst_occ", 32'(a_occ), 32'd0);
    end

    // Forward-register stream: 100 beats, latency 3, no bubbles
    b_or = 1'b1;
    for (int c = 0; c < 106; c++) begin
      next_cycle();
      b_iv = (c < 100);
      b_id = 32'(c + 1);
      @(negedge clk);
      if (c < 100) chk_b("b_str_ir", b_ir, 1'b1);
      chk_b("b_str_ov", b_ov, (c >= 3 && c <= 102));
      if (c >= 3 && c <= 102) chk_w("b_str_od", b_od, 32'(c - 2));
    end
    b_iv = 1'b0;

    // Random valid/ready with scoreboards
    ma = 0; mb = 0; a_seq = 1000; b_seq = 5000;
    a_stall = 1'b0; a_prev_od = '0;
    for (int c = 0; c < 3020; c++) begin
      next_cycle();
      a_iv = (c < 3000) ? 1'($urandom_range(0, 1)) : 1'b0;
      a_or = (c < 3000) ? 1'($urandom_range(0, 1)) : 1'b1;
      a_id = 32'(a_seq);
      b_iv = (c < 3000) ? 1'($urandom_range(0, 1)) : 1'b0;
      b_or = (c < 3000) ? 1'($urandom_range(0, 1)) : 1'b1;
      b_id = 32'(b_seq);
      @(negedge clk);
      chk_w("a_rnd_occ", 32'(a_occ), 32'(ma));
      if (ma == 4) chk_b("a_rnd_full_ir", a_ir, 1'b0);
      if (a_stall && a_ov) chk_w("a_rnd_stable", a_od, a_prev_od);
      a_stall   = a_ov & ~a_or;
      a_prev_od = a_od;
      if (a_iv && a_ir) begin
        qa.push_back(a_id);
        ma++;
        a_seq++;
      end
      if (a_ov && a_or) begin
        if (qa.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL a_rnd_extra: actual=%0h expected=none", a_od);
        end else begin
          exp_d = qa.pop_front();
          chk_w("a_rnd_data", a_od, exp_d);
        end
        ma--;
      end
      chk_w("b_rnd_occ", 32'(b_occ), 32'(mb));
      if (b_iv && b_ir) begin
        qb.push_back(b_id);
        mb++;
        b_seq++;
      end
      if (b_ov && b_or) begin
        if (qb.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL b_rnd_extra: actual=%0h expected=none", b_od);
        end else begin
          exp_d = qb.pop_front();
          chk_w("b_rnd_data", b_od, exp_d);
        end
        mb--;
      end
      // in_ready must not react to out_ready within the cycle
      tmp_ir = a_ir;
      a_or = ~a_or;
      #1;
      chk_b("a_comb_path", a_ir, tmp_ir);
      a_or = ~a_or;
    end
    chk_w("a_rnd_left", 32'(qa.size()), 32'd0);
    chk_w("b_rnd_left", 32'(qb.size()), 32'd0);
    chk_w("a_rnd_end_occ", 32'(a_occ), 32'd0);
    chk_w("b_rnd_end_occ", 32'(b_occ), 32'd0);
    chk_b("a_rnd_moved", (a_seq > 1500), 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_reg_channel.md
AXI_REG_CHANNEL -- requirements
Module: axi_reg_channel

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: payload width in bits, range 1..1024.
REQ-002 SHALL have parameter NUM_STAGES, default 2: number of cascaded register stages, range 1..16; ignored when MODE=0.
REQ-003 SHALL have parameter MODE, default 2: 0 = bypass, 1 = forward register, 2 = full skid buffer.
REQ-004 SHALL have port clk, input, 1: the single clock; all state on its rising edge.
REQ-005 SHALL have port arst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1: upstream beat valid.
REQ-007 SHALL have port in_data, input, DATA_WIDTH: upstream payload.
REQ-008 SHALL have port in_ready, output, 1: block accepts a beat this cycle.
REQ-009 SHALL have port out_valid, output, 1: downstream beat valid.
REQ-010 SHALL have port out_data, output, DATA_WIDTH: downstream payload.
REQ-011 SHALL have port out_ready, input, 1: downstream accepts a beat.
REQ-012 SHALL have port occupancy, output, $clog2(2*NUM_STAGES+1): number of beats currently held.
REQ-013 SHALL have port idle, output, 1: high when occupancy is 0.

Function
REQ-014 A transfer SHALL occur on either side only when valid and ready are both high at a rising clk edge.
REQ-015 MODE=0: out_valid=in_valid, out_data=in_data, in_ready=out_ready, all combinational; occupancy=0 and idle=1 constantly.
REQ-016 MODE=1: each stage SHALL hold one beat (valid_q, data_q); stage ready = next_ready OR NOT valid_q; capacity NUM_STAGES.
REQ-017 MODE=2: each stage SHALL hold main and skid registers, with states EMPTY (0 beats), BUSY (main only) and FULL (main+skid); capacity 2*NUM_STAGES.
REQ-018 MODE=2 stage transitions: EMPTY+push->BUSY; BUSY+push+no pop->FULL; BUSY+pop+no push->EMPTY; BUSY+push+pop->BUSY; FULL+pop->BUSY, with skid moved into main.
REQ-019 MODE=2 stage ready SHALL equal (state != FULL), registered, with no combinational path from out_ready to in_ready.
REQ-020 Stage output valid SHALL be high in BUSY/FULL and output data SHALL come from the main register; push is never accepted in FULL.
REQ-021 Latency in MODE 1/2 SHALL be exactly NUM_STAGES cycles from the input handshake edge to out_valid high, with all stages empty.
REQ-022 With in_valid and out_ready held high, throughput SHALL be one beat per cycle with no bubbles in MODE 1/2.
REQ-023 Beat order SHALL be preserved; no beat SHALL be dropped or duplicated; out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-024 occupancy SHALL be updated each edge as +1 on input handshake, -1 on output handshake, and unchanged when both occur in the same cycle.
REQ-025 occupancy SHALL never exceed capacity; in_ready SHALL be 0 whenever occupancy equals capacity.
REQ-026 Simultaneous push and pop in a FULL stage SHALL be impossible by construction (ready=0); pop alone SHALL be serviced.

Reset
REQ-027 On arst high, all stages SHALL go immediately to EMPTY/invalid and all data registers SHALL go to 0, without waiting for clk.
REQ-028 During reset: out_valid=0, out_data=0, occupancy=0, idle=1, in_ready=0 (MODE 1/2).
REQ-029 Beats held when reset asserts mid-operation SHALL be discarded.
REQ-030 in_ready SHALL rise on the first clk edge after arst deasserts.

Verification
REQ-031 MODE=2, NUM_STAGES=2: push single beat 0xA5A5A5A5 with out_ready=1 -> out_valid high 2 cycles later with out_data=0xA5A5A5A5; occupancy 1 then 0.
REQ-032 MODE=2, NUM_STAGES=2: out_ready=0, stream 0x1,0x2,... -> exactly 4 accepted, in_ready=0, occupancy=4; then out_ready=1 -> 0x1..0x4 emitted in order, in back-to-back cycles.
REQ-033 MODE=1, NUM_STAGES=3: 100 beats with in_valid=out_ready=1 -> 100 beats in 102 cycles after the first, in order, with no bubbles.
REQ-034 MODE=0: toggle out_ready randomly -> in_ready mirrors it in the same cycle; out_data equals in_data; occupancy=0.
REQ-035 MODE=2: fill to occupancy=3, assert arst asynchronously mid-cycle -> out_valid=0 and occupancy=0 before the next edge; no stale beat emitted after release.
REQ-036 Random valid/ready, 10k beats, all modes with NUM_STAGES in {1,4} -> scoreboard ordered match; occupancy matches the model; no combinational out_ready->in_ready path in MODE=2.
